// File: rtl/cory_arb8.sv
// cory_arb8 -- eight-channel round-robin merge onto one registered output.
//
// Parameter:
//   N            payload width of every channel (default 16)
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous active-high reset
//   i_aK_v       channel K valid            (K = 0..7)
//   i_aK_d       channel K payload, N bits  (K = 0..7)
//   i_aK_l       channel K last-beat flag   (K = 0..7, lock build only)
//   o_aK_r       channel K ready            (K = 0..7)
//   o_z_v        merged output valid
//   o_z_d        merged output payload
//   o_z_id       source channel of o_z_d
//   o_z_l        last-beat flag of o_z_d    (lock build only)
//   i_z_r        downstream ready
//
// Optional feature: define CORY_ARB8_LOCK_EN to add packet locking. A beat
// loaded with l = 0 locks the grant to its channel; the beat with l = 1
// releases the lock and only then advances the round-robin pointer.
//
// Handshake: every channel (inputs and output) uses strict valid/ready. A
// beat moves when valid and ready are both 1 at a rising clk edge. Sources
// may drop valid at any time; an ungranted channel is simply skipped.
// o_aK_r depends combinationally on the valid inputs. Once o_z_v is 1 the
// output beat holds stable until i_z_r accepts it.

module cory_arb8 #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_a0_v,
  input  logic         i_a1_v,
  input  logic         i_a2_v,
  input  logic         i_a3_v,
  input  logic         i_a4_v,
  input  logic         i_a5_v,
  input  logic         i_a6_v,
  input  logic         i_a7_v,
  input  logic [N-1:0] i_a0_d,
  input  logic [N-1:0] i_a1_d,
  input  logic [N-1:0] i_a2_d,
  input  logic [N-1:0] i_a3_d,
  input  logic [N-1:0] i_a4_d,
  input  logic [N-1:0] i_a5_d,
  input  logic [N-1:0] i_a6_d,
  input  logic [N-1:0] i_a7_d,
`ifdef CORY_ARB8_LOCK_EN
  input  logic         i_a0_l,
  input  logic         i_a1_l,
  input  logic         i_a2_l,
  input  logic         i_a3_l,
  input  logic         i_a4_l,
  input  logic         i_a5_l,
  input  logic         i_a6_l,
  input  logic         i_a7_l,
  output logic         o_z_l,
`endif
  output logic         o_a0_r,
  output logic         o_a1_r,
  output logic         o_a2_r,
  output logic         o_a3_r,
  output logic         o_a4_r,
  output logic         o_a5_r,
  output logic         o_a6_r,
  output logic         o_a7_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic [2:0]   o_z_id,
  input  logic         i_z_r
);

  logic [7:0]   v_vec;
  logic [N-1:0] d_arr [8];
  logic [7:0]   r_vec;
  logic [2:0]   ptr;
  logic         ld;
  logic         gnt_found;
  logic [2:0]   gnt_id;
  logic [2:0]   idx;

  assign v_vec = {i_a7_v, i_a6_v, i_a5_v, i_a4_v, i_a3_v, i_a2_v, i_a1_v, i_a0_v};

  assign d_arr[0] = i_a0_d;
  assign d_arr[1] = i_a1_d;
  assign d_arr[2] = i_a2_d;
  assign d_arr[3] = i_a3_d;
  assign d_arr[4] = i_a4_d;
  assign d_arr[5] = i_a5_d;
  assign d_arr[6] = i_a6_d;
  assign d_arr[7] = i_a7_d;

`ifdef CORY_ARB8_LOCK_EN
  logic [7:0] l_vec;
  logic       locked;
  logic [2:0] lock_id;

  assign l_vec = {i_a7_l, i_a6_l, i_a5_l, i_a4_l, i_a3_l, i_a2_l, i_a1_l, i_a0_l};
`endif

  // The output register can take a new beat when empty or being drained.
  assign ld = !o_z_v || i_z_r;

  // Search ptr, ptr+1, ... ptr+7; the 3-bit add wraps modulo 8 for free.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = 3'd0;
    idx       = 3'd0;
    for (int off = 0; off < 8; off++) begin
      idx = ptr + 3'(off);
      if (!gnt_found && v_vec[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
`ifdef CORY_ARB8_LOCK_EN
    // A locked packet owns the arbiter even while its source is idle.
    if (locked) begin
      gnt_found = v_vec[lock_id];
      gnt_id    = lock_id;
    end
`endif
  end

  // One-hot ready; suppressed during reset so no beat is lost into a
  // register that is being cleared.
  always_comb begin
    r_vec = 8'd0;
    if (ld && gnt_found && !reset) begin
      r_vec[gnt_id] = 1'b1;
    end
  end

  assign o_a0_r = r_vec[0];
  assign o_a1_r = r_vec[1];
  assign o_a2_r = r_vec[2];
  assign o_a3_r = r_vec[3];
  assign o_a4_r = r_vec[4];
  assign o_a5_r = r_vec[5];
  assign o_a6_r = r_vec[6];
  assign o_a7_r = r_vec[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_z_v   <= 1'b0;
      o_z_d   <= '0;
      o_z_id  <= 3'd0;
      ptr     <= 3'd0;
`ifdef CORY_ARB8_LOCK_EN
      o_z_l   <= 1'b0;
      locked  <= 1'b0;
      lock_id <= 3'd0;
`endif
    end else if (ld) begin
      if (gnt_found) begin
        o_z_v  <= 1'b1;
        o_z_d  <= d_arr[gnt_id];
        o_z_id <= gnt_id;
`ifdef CORY_ARB8_LOCK_EN
        o_z_l  <= l_vec[gnt_id];
        if (l_vec[gnt_id]) begin
          locked <= 1'b0;
          ptr    <= gnt_id + 3'd1;
        end else begin
          locked  <= 1'b1;
          lock_id <= gnt_id;
        end
`else
        ptr    <= gnt_id + 3'd1;
`endif
      end else begin
        // Nothing to send: payload, id and pointer keep their values.
        o_z_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cory_arb8.sv
// tb_cory_arb8 -- randomized and directed bench for cory_arb8 with a
// behavioural round-robin model, per-cycle compare and a beat scoreboard.
// Build with CORY_ARB8_LOCK_EN defined to exercise packet locking.

module tb_cory_arb8;

  localparam int N = 16;

  logic         clk;
  logic         reset;
  logic [7:0]   tv;
  logic [N-1:0] td [8];
  logic [7:0]   tl;
  logic [7:0]   dr;
  logic         tz_r;
  logic         o_z_v;
  logic [N-1:0] o_z_d;
  logic [2:0]   o_z_id;
  logic         o_z_l;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model state
  bit           m_v = 1'b0;
  logic [N-1:0] m_d = '0;
  int           m_id = 0;
  int           m_ptr = 0;
  bit           m_lock = 1'b0;
  int           m_lock_id = 0;
  bit           m_l = 1'b0;
  int           mg;
  logic [N+2:0] exp_q [$];

  cory_arb8 #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_a0_v (tv[0]), .i_a1_v (tv[1]), .i_a2_v (tv[2]), .i_a3_v (tv[3]),
    .i_a4_v (tv[4]), .i_a5_v (tv[5]), .i_a6_v (tv[6]), .i_a7_v (tv[7]),
    .i_a0_d (td[0]), .i_a1_d (td[1]), .i_a2_d (td[2]), .i_a3_d (td[3]),
    .i_a4_d (td[4]), .i_a5_d (td[5]), .i_a6_d (td[6]), .i_a7_d (td[7]),
`ifdef CORY_ARB8_LOCK_EN
    .i_a0_l (tl[0]), .i_a1_l (tl[1]), .i_a2_l (tl[2]), .i_a3_l (tl[3]),
    .i_a4_l (tl[4]), .i_a5_l (tl[5]), .i_a6_l (tl[6]), .i_a7_l (tl[7]),
    .o_z_l  (o_z_l),
`endif
    .o_a0_r (dr[0]), .o_a1_r (dr[1]), .o_a2_r (dr[2]), .o_a3_r (dr[3]),
    .o_a4_r (dr[4]), .o_a5_r (dr[5]), .o_a6_r (dr[6]), .o_a7_r (dr[7]),
    .o_z_v  (o_z_v),
    .o_z_d  (o_z_d),
    .o_z_id (o_z_id),
    .i_z_r  (tz_r)
  );

`ifndef CORY_ARB8_LOCK_EN
  assign o_z_l = 1'b0;
`endif

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  // Channel that wins under the rules: the locked channel if a packet is
  // open, otherwise the first valid channel scanning from the pointer.
  function automatic int model_grant();
    if (m_lock) return tv[m_lock_id] ? m_lock_id : -1;
    for (int k = 0; k < 8; k++) begin
      if (tv[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_ready();
    int g;
    g = model_grant();
    if (reset || (m_v && !tz_r) || g < 0) return 8'd0;
    return 8'(1 << g);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_v       <= 1'b0;
      m_d       <= '0;
      m_id      <= 0;
      m_ptr     <= 0;
      m_lock    <= 1'b0;
      m_lock_id <= 0;
      m_l       <= 1'b0;
      exp_q.delete();
    end else if (!m_v || tz_r) begin
      mg = model_grant();
      if (mg >= 0) begin
        m_v  <= 1'b1;
        m_d  <= td[mg];
        m_id <= mg;
        exp_q.push_back({3'(mg), td[mg]});
`ifdef CORY_ARB8_LOCK_EN
        m_l <= tl[mg];
        if (tl[mg]) begin
          m_lock <= 1'b0;
          m_ptr  <= (mg + 1) % 8;
        end else begin
          m_lock    <= 1'b1;
          m_lock_id <= mg;
        end
`else
        m_ptr <= (mg + 1) % 8;
`endif
      end else begin
        m_v <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("z_v", 32'(o_z_v), 32'(m_v));
      chk("z_d", 32'(o_z_d), 32'(m_d));
      chk("z_id", 32'(o_z_id), 32'(m_id));
      chk("ready", 32'(dr), 32'(model_ready()));
`ifdef CORY_ARB8_LOCK_EN
      chk("z_l", 32'(o_z_l), 32'(m_l));
`endif
      // Scoreboard: a beat leaving at the next edge must be the oldest one
      // the model saw accepted.
      if (o_z_v && tz_r && !reset) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got beat 0x%0h expected none at %0t", {o_z_id, o_z_d}, $time);
        end else begin
          chk("sb_beat", 32'({o_z_id, o_z_d}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tv    = 8'd0;
    tl    = 8'hff;
    tz_r  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    tv    = 8'd0;
    tl    = 8'hff;
    tz_r  = 1'b1;
    for (int k = 0; k < 8; k++) td[k] = '0;
    cmp_en = 1'b1;

    // Reset state
    do_reset();
    chk("rst_v", 32'(o_z_v), 32'd0);
    chk("rst_d", 32'(o_z_d), 32'd0);
    chk("rst_ready", 32'(dr), 32'd0);

    // Channels 2 and 5: 2 then 5, pointer ends at 6
    tv = 8'h24; td[2] = 16'h0002; td[5] = 16'h0005;
    step();
    chk("s2_v", 32'(o_z_v), 32'd1);
    chk("s2_d", 32'(o_z_d), 32'h0002);
    chk("s2_id", 32'(o_z_id), 32'd2);
    step();
    chk("s5_d", 32'(o_z_d), 32'h0005);
    chk("s5_id", 32'(o_z_id), 32'd5);
    tv = 8'hff;
    step();
    chk("ptr6_id", 32'(o_z_id), 32'd6);
    tv = 8'h00;

    // All eight valid: 0..7 twice, no bubbles
    do_reset();
    tv = 8'hff;
    for (int k = 0; k < 8; k++) td[k] = 16'(16'h0100 + k);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("rr_v", 32'(o_z_v), 32'd1);
      chk("rr_id", 32'(o_z_id), 32'(i % 8));
      chk("rr_d", 32'(o_z_d), 32'(16'h0100 + (i % 8)));
    end
    tv = 8'h00;

    // Stall for five cycles holding 0x1234, then 0x1235 with no gap
    do_reset();
    tv = 8'h02; td[1] = 16'h1234;
    step();
    chk("st_d0", 32'(o_z_d), 32'h1234);
    tz_r = 1'b0; td[1] = 16'h1235;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_v", 32'(o_z_v), 32'd1);
      chk("st_d", 32'(o_z_d), 32'h1234);
      chk("st_id", 32'(o_z_id), 32'd1);
      chk("st_ready", 32'(dr), 32'd0);
    end
    tz_r = 1'b1;
    step();
    chk("st_next_v", 32'(o_z_v), 32'd1);
    chk("st_next_d", 32'(o_z_d), 32'h1235);
    tv = 8'h00;
    step();
    chk("st_idle_v", 32'(o_z_v), 32'd0);

    // Wrap-around: 7, then 0, then 6
    do_reset();
    tv = 8'h80; td[7] = 16'h0077;
    step();
    chk("wr_id7", 32'(o_z_id), 32'd7);
    tv = 8'h41; td[0] = 16'h0010; td[6] = 16'h0060;
    step();
    chk("wr_id0", 32'(o_z_id), 32'd0);
    step();
    chk("wr_id6", 32'(o_z_id), 32'd6);
    tv = 8'h00;

    // Reset in the middle of a stalled beat
    do_reset();
    tv = 8'h08; td[3] = 16'h0033;
    step();
    chk("mr_id3", 32'(o_z_id), 32'd3);
    tz_r = 1'b0;
    step();
    chk("mr_hold_v", 32'(o_z_v), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mr_v", 32'(o_z_v), 32'd0);
    chk("mr_d", 32'(o_z_d), 32'd0);
    chk("mr_ready", 32'(dr), 32'd0);
    step();
    reset = 1'b0;
    tv = 8'h44; td[2] = 16'h0022; td[6] = 16'h0066; tz_r = 1'b1;
    step();
    chk("mr_first_id", 32'(o_z_id), 32'd2);
    tv = 8'h00;

`ifdef CORY_ARB8_LOCK_EN
    // Three-beat packet on channel 3 with channel 4 waiting
    do_reset();
    tv = 8'h18;
    td[3] = 16'h0031; tl[3] = 1'b0;
    td[4] = 16'h0040; tl[4] = 1'b1;
    step();
    chk("lk_id1", 32'(o_z_id), 32'd3);
    chk("lk_l1", 32'(o_z_l), 32'd0);
    td[3] = 16'h0032;
    step();
    chk("lk_id2", 32'(o_z_id), 32'd3);
    chk("lk_l2", 32'(o_z_l), 32'd0);
    td[3] = 16'h0033; tl[3] = 1'b1;
    step();
    chk("lk_id3", 32'(o_z_id), 32'd3);
    chk("lk_d3", 32'(o_z_d), 32'h0033);
    chk("lk_l3", 32'(o_z_l), 32'd1);
    tv = 8'h10;
    step();
    chk("lk_id4", 32'(o_z_id), 32'd4);
    tv = 8'h00;
`endif

    // Randomized traffic, checked every cycle by the compare process
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 3))
        0:       tv = 8'hff;
        1:       tv = 8'(1 << $urandom_range(0, 7));
        default: tv = 8'($urandom);
      endcase
      tl = 8'($urandom);
      for (int k = 0; k < 8; k++) td[k] = 16'($urandom);
      tz_r = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0;
    tv = 8'h00;
    tz_r = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cory_arb8.md
CORY_ARB8 -- requirements
Module: cory_arb8

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning the payload width in bits of every channel.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have ports i_aK_v, input, 1 bit, for K = 0..7: channel K valid.
REQ-005 The block SHALL have ports i_aK_d, input, N bits, for K = 0..7: channel K payload.
REQ-006 The block SHALL have ports o_aK_r, output, 1 bit, for K = 0..7: channel K ready.
REQ-007 The block SHALL have port o_z_v, output, 1 bit: merged output valid.
REQ-008 The block SHALL have port o_z_d, output, N bits: merged output payload.
REQ-009 The block SHALL have port o_z_id, output, 3 bits: index of the source channel of the current o_z_d.
REQ-010 The block SHALL have port i_z_r, input, 1 bit: downstream ready.

Function
REQ-011 The block SHALL merge eight valid/ready input channels into one output stream with round-robin arbitration; a transfer occurs on any channel where valid and ready are both 1 at a rising clk edge.
REQ-012 The output SHALL be a single registered stage; load enable ld = !o_z_v | i_z_r.
REQ-013 The grant SHALL be the first channel with i_aK_v = 1 searched in the order ptr, ptr+1, ..., ptr+7, taken modulo 8.
REQ-014 o_aK_r SHALL be ld AND (grant == K), with at most one o_aK_r high per cycle; ready may depend combinationally on the valid inputs.
REQ-015 On ld with a grant, the next cycle SHALL have o_z_v = 1, o_z_d = the granted payload, o_z_id = K, and ptr = (K+1) mod 8, so channel 7 wraps to channel 0.
REQ-016 On ld with no valid input, the next cycle SHALL have o_z_v = 0; o_z_d, o_z_id and ptr SHALL hold.
REQ-017 While o_z_v = 1 and i_z_r = 0, o_z_v, o_z_d and o_z_id SHALL hold stable and every o_aK_r SHALL be 0.
REQ-018 Latency SHALL be exactly 1 cycle from input transfer to o_z_v; sustained throughput SHALL be 1 beat per cycle when i_z_r = 1.
REQ-019 With all eight channels continuously valid, each channel SHALL be granted exactly once per 8 consecutive grants.
REQ-020 A channel whose valid drops while it is not granted SHALL be skipped without penalty to other channels.

Reset
REQ-021 Asserting reset SHALL immediately force o_z_v = 0, o_z_d = 0, o_z_id = 0, ptr = 0 (channel 0 highest priority) and the lock clear; this applies mid-operation as well.
REQ-022 While reset is high, every o_aK_r SHALL be 0 and any held output beat SHALL be discarded.

Configuration
REQ-023 With macro CORY_ARB8_LOCK_EN defined, the block SHALL add inputs i_aK_l (1 bit, last beat of a packet) and output o_z_l (registered alongside o_z_d).
REQ-024 With CORY_ARB8_LOCK_EN defined, loading a beat with l = 0 SHALL lock the grant to that channel; loading a beat with l = 1 SHALL release the lock and only then advance ptr.
REQ-025 While locked, other channels SHALL receive no ready even if the locked channel is idle.
REQ-026 Without CORY_ARB8_LOCK_EN, the l ports SHALL be absent and arbitration SHALL be per beat exactly as in REQ-013..REQ-015.

Verification
REQ-027 Scenario, after reset with i_z_r = 1: channels 2 and 5 valid with d = 0x0002 and 0x0005 -> 0x0002/id 2 then 0x0005/id 5 on consecutive cycles; ptr ends at 6.
REQ-028 Scenario, all 8 channels valid for 16 cycles with i_z_r = 1: o_z_id sequence 0,1,...,7,0,...,7 with o_z_v continuously 1.
REQ-029 Scenario, stall with i_z_r = 0 for 5 cycles while o_z_v = 1 and o_z_d = 0x1234: outputs stable, all o_aK_r = 0; on release, next beat follows with no gap or loss.
REQ-030 Scenario, channel 7 granted then channels 0 and 6 valid: the next grant is 0 (wrap-around), then 6.
REQ-031 Scenario, reset pulsed while o_z_v = 1 and i_z_r = 0: o_z_v = 0 asynchronously, o_z_d = 0, and the first grant after release goes to the lowest valid channel index.
REQ-032 Scenario, CORY_ARB8_LOCK_EN with channel 3 sending a 3-beat packet (l = 0,0,1) while channel 4 is valid: beats 3,3,3 are output before any beat 4, and o_z_l = 1 only on the third beat.
